// File: rtl/lb_pkg.sv
// Shared types and helpers for the 3x3 line-buffer controller.
package lb_pkg;

  localparam int COORD_W = 11;
  localparam int SLOT_W  = 2;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [SLOT_W-1:0]  slot_t;

  // Frame tracking: waiting for start of frame, filling rows 0-1, producing windows.
  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    FILL     = 2'd1,
    RUN      = 2'd2
  } lb_state_e;

  // Slots holding the top/centre/bottom rows of a window.
  typedef struct packed {
    slot_t top;
    slot_t mid;
    slot_t bot;
  } sel_t;

  function automatic slot_t slot_inc(input slot_t s);
    return (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  function automatic slot_t slot_dec(input slot_t s);
    return (s == 2'd0) ? 2'd2 : s - 2'd1;
  endfunction

  // Bottom row sits in slot s; the two rows above occupy s-1 and s-2 (== s+1 mod 3).
  function automatic sel_t make_sel(input slot_t s);
    sel_t r;
    r.top = slot_inc(s);
    r.mid = slot_dec(s);
    r.bot = s;
    return r;
  endfunction

endpackage

// File: rtl/line_buffer_ctrl.sv
// Write/read sequencer for a 3-slot line buffer producing a 3x3 window stream.
// Handshake: a beat transfers when s_tvalid & s_tready; s_tready is always 1, and
// the window stream has no backpressure (fixed latency).
module line_buffer_ctrl
  import lb_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int LINE_WIDTH   = 1920,
  parameter int FRAME_HEIGHT = 1080
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tuser,
  input  logic                  s_tlast,
  output logic                  en_wr,
  output logic [DATA_WIDTH-1:0] pixel_in,
  output logic [10:0]           write_x,
  output logic [1:0]            write_row,
  output logic                  en_rd,
  output logic [10:0]           read_x,
  output logic [1:0]            sel_top,
  output logic [1:0]            sel_mid,
  output logic [1:0]            sel_bot,
  output logic                  win_valid,
  output logic [10:0]           win_x,
  output logic [10:0]           win_y,
  output logic                  win_user,
  output logic                  win_last,
  output logic                  err_sync
);

  localparam coord_t LAST_X = coord_t'(LINE_WIDTH - 1);
  localparam coord_t LAST_Y = coord_t'(FRAME_HEIGHT - 1);

  lb_state_e state_q, state_d;
  coord_t    x_q, y_q;
  slot_t     slot_q;

  logic   accept, beat_ok, frame_err, restart, take, drop_pipe;
  logic   rd_issue, fl_issue;
  coord_t bx, by;
  slot_t  bslot;

  // Read pipeline: request stage, flush delay stages, and the data travelling with en_rd.
  logic   rq_v, fl1_v, fl2_v;
  coord_t rq_x, rq_y, fl_y, rd_y;
  sel_t   rq_sel, fl_sel, rd_sel;

  assign s_tready = 1'b1;
  assign accept   = s_tvalid & s_tready;

  // Beat classification and next-state decode.
  always_comb begin
    bx        = s_tuser ? '0 : x_q;
    by        = s_tuser ? '0 : y_q;
    bslot     = s_tuser ? '0 : slot_q;
    beat_ok   = accept & (s_tuser | (state_q != WAIT_SOF));
    frame_err = beat_ok & (s_tlast != (bx == LAST_X));
    restart   = beat_ok & s_tuser & (state_q != WAIT_SOF);
    take      = beat_ok & ~frame_err;
    drop_pipe = frame_err | restart;
    rd_issue  = take & (by >= coord_t'(2)) & (bx != '0);
    fl_issue  = take & (by >= coord_t'(2)) & s_tlast;
    state_d   = state_q;
    if (frame_err) begin
      state_d = WAIT_SOF;
    end else if (take) begin
      if (s_tlast) begin
        if (by == LAST_Y)             state_d = WAIT_SOF;
        else if (by >= coord_t'(1))   state_d = RUN;
        else                          state_d = FILL;
      end else begin
        state_d = (by >= coord_t'(2)) ? RUN : FILL;
      end
    end
  end

  // State register, pixel position counters and sticky framing error.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= WAIT_SOF;
      x_q      <= '0;
      y_q      <= '0;
      slot_q   <= '0;
      err_sync <= 1'b0;
    end else begin
      state_q <= state_d;
      if (frame_err | restart) err_sync <= 1'b1;
      if (take) begin
        if (s_tlast) begin
          x_q    <= '0;
          y_q    <= (by == LAST_Y) ? '0 : by + coord_t'(1);
          slot_q <= (by == LAST_Y) ? '0 : slot_inc(bslot);
        end else begin
          x_q    <= bx + coord_t'(1);
          y_q    <= by;
          slot_q <= bslot;
        end
      end
    end
  end

  // Write port: every kept beat is written one cycle after it is accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      en_wr     <= 1'b0;
      pixel_in  <= '0;
      write_x   <= '0;
      write_row <= '0;
    end else begin
      en_wr <= take;
      if (take) begin
        pixel_in  <= s_tdata;
        write_x   <= bx;
        write_row <= bslot;
      end
    end
  end

  // Read scheduling: column x-1 is read two cycles after pixel x; the last column of a
  // line is read one cycle later still, into the slot left free by the next line's pixel 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rq_v   <= 1'b0;
      rq_x   <= '0;
      rq_y   <= '0;
      rq_sel <= '0;
      fl1_v  <= 1'b0;
      fl2_v  <= 1'b0;
      fl_y   <= '0;
      fl_sel <= '0;
      en_rd  <= 1'b0;
      read_x <= '0;
      rd_y   <= '0;
      rd_sel <= '0;
    end else begin
      rq_v  <= rd_issue;
      fl1_v <= fl_issue;
      fl2_v <= fl1_v & ~drop_pipe;
      en_rd <= (rq_v | fl2_v) & ~drop_pipe;
      if (rd_issue) begin
        rq_x   <= bx - coord_t'(1);
        rq_y   <= by - coord_t'(1);
        rq_sel <= make_sel(bslot);
      end
      if (fl_issue) begin
        fl_y   <= by - coord_t'(1);
        fl_sel <= make_sel(bslot);
      end
      if (rq_v | fl2_v) begin
        read_x <= fl2_v ? LAST_X : rq_x;
        rd_y   <= fl2_v ? fl_y   : rq_y;
        rd_sel <= fl2_v ? fl_sel : rq_sel;
      end
    end
  end

  // Window tags: presented the cycle after the read, alongside the buffer's p00..p22.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      win_valid <= 1'b0;
      win_user  <= 1'b0;
      win_last  <= 1'b0;
      win_x     <= '0;
      win_y     <= '0;
      sel_top   <= '0;
      sel_mid   <= '0;
      sel_bot   <= '0;
    end else begin
      win_valid <= en_rd & ~drop_pipe;
      win_user  <= en_rd & ~drop_pipe & (read_x == '0) & (rd_y == coord_t'(1));
      win_last  <= en_rd & ~drop_pipe & (read_x == LAST_X);
      if (en_rd) begin
        win_x   <= read_x;
        win_y   <= rd_y;
        sel_top <= rd_sel.top;
        sel_mid <= rd_sel.mid;
        sel_bot <= rd_sel.bot;
      end
    end
  end

endmodule
